aes_encrypt_core: RTL

//  Iterative AES-128 encryption engine, one full round per clock. It is the forward (cipher)

---
 rtl/aes_enc_pkg.sv | 37 +++
 rtl/aes_sbox.sv | 40 ++++
 rtl/aes_encrypt_core.sv | 124 ++++++++++++
 3 files changed

// File: rtl/aes_enc_pkg.sv
// Shared types and GF(2^8) helpers for the iterative AES-128 encryption core.
// State layout: [127:120] is byte 0; bytes run column-major (byte = 4*col + row).
package aes_enc_pkg;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} enc_state_t;

  typedef logic [31:0] word_t;

  localparam logic [7:0] RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic word_t mix_column(input word_t col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Row r rotates left by r: out(r,c) = in(r, (c+r) mod 4).
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box: multiplicative inverse in GF(2^8) (as x^254)
// followed by the FIPS-197 affine transform.
module aes_sbox
  import aes_enc_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

  // Addition chain to x^254; zero maps to zero as the S-box definition requires.
  always_comb begin
    x2   = gf_mul(in_byte, in_byte);
    x3   = gf_mul(x2, in_byte);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    inv  = gf_mul(x252, x2);
    out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_encrypt_core.sv
// Iterative AES-128 encryptor, one round per clock, START/DONE level handshake.
// Build option AES_ENC_ZEROIZE_EN clears state, round key and ciphertext on DONE->IDLE.
module aes_encrypt_core
  import aes_enc_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         AES_START,
  input  logic [127:0] AES_KEY,
  input  logic [127:0] AES_MSG_PLAIN,
  output logic [127:0] AES_MSG_ENC,
  output logic         AES_DONE
);

  if (NR != 10) begin : g_nr_check
    $error("aes_encrypt_core: only NR=10 (AES-128) is supported");
  end

  enc_state_t   fsm_q, fsm_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] state_q, state_d;
  logic [127:0] rkey_q, rkey_d;
  logic [127:0] enc_q, enc_d;
  logic         done_q, done_d;

  logic [127:0] sb_state, sr_state, mc_state, key_next;
  word_t        rot_w, sub_w, w0n, w1n, w2n, w3n;
  logic [7:0]   rcon_cur;

  for (genvar i = 0; i < 16; i++) begin : g_sub_bytes
    aes_sbox u_sbox (
      .in_byte  (state_q[127-8*i -: 8]),
      .out_byte (sb_state[127-8*i -: 8])
    );
  end

  assign rot_w = {rkey_q[23:0], rkey_q[31:24]};

  for (genvar j = 0; j < 4; j++) begin : g_sub_word
    aes_sbox u_sbox (
      .in_byte  (rot_w[31-8*j -: 8]),
      .out_byte (sub_w[31-8*j -: 8])
    );
  end

  always_comb begin
    rcon_cur = (round_q >= 4'd1 && round_q <= 4'd10) ? RCON[round_q] : 8'h00;
    w0n      = rkey_q[127:96] ^ sub_w ^ {rcon_cur, 24'h0};
    w1n      = rkey_q[95:64] ^ w0n;
    w2n      = rkey_q[63:32] ^ w1n;
    w3n      = rkey_q[31:0] ^ w2n;
    key_next = {w0n, w1n, w2n, w3n};
    sr_state = shift_rows(sb_state);
    mc_state = {mix_column(sr_state[127:96]), mix_column(sr_state[95:64]),
                mix_column(sr_state[63:32]),  mix_column(sr_state[31:0])};
  end

  always_comb begin
    fsm_d   = fsm_q;
    round_d = round_q;
    state_d = state_q;
    rkey_d  = rkey_q;
    enc_d   = enc_q;
    done_d  = done_q;
    unique case (fsm_q)
      IDLE: begin
        if (AES_START) begin
          state_d = AES_MSG_PLAIN ^ AES_KEY;
          rkey_d  = AES_KEY;
          round_d = 4'd1;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        rkey_d  = key_next;
        state_d = mc_state ^ key_next;
        round_d = round_q + 4'd1;
        if (round_q == 4'd9) fsm_d = FINAL;
      end
      FINAL: begin
        enc_d  = sr_state ^ key_next;
        done_d = 1'b1;
        fsm_d  = DONE;
      end
      DONE: begin
        // No auto-restart: START must fall before a new operation is accepted.
        if (!AES_START) begin
          done_d = 1'b0;
          fsm_d  = IDLE;
`ifdef AES_ENC_ZEROIZE_EN
          state_d = '0;
          rkey_d  = '0;
          enc_d   = '0;
`endif
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      fsm_q   <= IDLE;
      round_q <= '0;
      state_q <= '0;
      rkey_q  <= '0;
      enc_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      state_q <= state_d;
      rkey_q  <= rkey_d;
      enc_q   <= enc_d;
      done_q  <= done_d;
    end
  end

  assign AES_MSG_ENC = enc_q;
  assign AES_DONE    = done_q;

endmodule
